// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory hierarchy: word/line types, the pmem
// responder state encoding and a small width helper.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_data;

    localparam int LINE_BYTES = 16;
    localparam int LINE_BITS  = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        RESP = 2'd3
    } pmem_state_t;

    // Counter/address width for a range of 'value' states, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = $clog2(value);
        if (width < 1) begin
            width = 1;
        end else begin
            width = width;
        end
        return width;
    endfunction

endpackage

// File: rtl/pmem_line_responder_beat_sram.sv
// Single-port beat store: synchronous write, registered read.
// Contents are deliberately not reset so the store behaves like real memory.
module beat_sram
    import lc3b_types::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8192,
    localparam int ADDR_W = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write the addressed word when enabled; always register the old contents out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/pmem_line_responder.sv
// Memory-side responder for the 128-bit cache-line pmem interface.
// A request is captured in IDLE, waits LATENCY cycles, moves the line one
// beat per cycle to/from the beat store, then pulses pmem_resp for a cycle.
module pmem_line_responder
    import lc3b_types::*;
#(
    parameter int LATENCY    = 4,
    parameter int BEAT_WIDTH = 64,
    parameter int INDEX_BITS = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         pmem_error,
    output logic         busy
);

    localparam int NUM_BEATS = LINE_BITS / BEAT_WIDTH;
    localparam int WAIT_W    = clog2_min1(LATENCY);
    localparam int BEAT_W    = clog2_min1(NUM_BEATS);
    localparam int DEPTH     = (2 ** INDEX_BITS) * NUM_BEATS;
    localparam int ADDR_W    = clog2_min1(DEPTH);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    pmem_state_t             state_r;
    pmem_state_t             state_next_s;
    logic                    op_write_r;
    logic [INDEX_BITS-1:0]   index_r;
    logic [WAIT_W-1:0]       wait_cnt_r;
    logic [BEAT_W-1:0]       beat_cnt_r;
    logic [LINE_BITS-1:0]    line_buf_r;
    logic [LINE_BITS-1:0]    rdata_r;
    logic [LINE_BITS-1:0]    rdata_full_s;
    logic                    resp_r;
    logic                    error_r;
    logic                    busy_r;
    logic                    sram_we_s;
    logic [ADDR_W-1:0]       sram_addr_s;
    logic [BEAT_WIDTH-1:0]   sram_wdata_s;
    logic [BEAT_WIDTH-1:0]   sram_rdata_s;
    logic                    addr_unused_s;

    // Offset bits and any address bits above the line index never select storage.
    assign addr_unused_s = ^pmem_address;

    beat_sram #(
        .WIDTH (BEAT_WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (clk),
        .we    (sram_we_s),
        .addr  (sram_addr_s),
        .wdata (sram_wdata_s),
        .rdata (sram_rdata_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE -> WAIT -> XFER -> RESP -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pmem_read | pmem_write) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == {WAIT_W{1'b0}}) begin
                    state_next_s = XFER;
                end else begin
                    state_next_s = WAIT;
                end
            end
            XFER: begin
                if (beat_cnt_r == LAST_BEAT) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = XFER;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Store port and read-line assembly. The last read beat is still in the
    // store's output register during RESP, so it is spliced in here.
    always_comb begin
        sram_we_s    = (state_r == XFER) & op_write_r;
        sram_addr_s  = (ADDR_W'(index_r) * ADDR_W'(NUM_BEATS)) + ADDR_W'(beat_cnt_r);
        sram_wdata_s = line_buf_r[int'(beat_cnt_r) * BEAT_WIDTH +: BEAT_WIDTH];
        rdata_full_s = line_buf_r;
        rdata_full_s[(NUM_BEATS - 1) * BEAT_WIDTH +: BEAT_WIDTH] = sram_rdata_s;
        if ((state_r == RESP) && !op_write_r) begin
            pmem_rdata = rdata_full_s;
        end else begin
            pmem_rdata = rdata_r;
        end
    end

    // Request capture, counters, line buffer, read-hold register and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write_r <= 1'b0;
            index_r    <= {INDEX_BITS{1'b0}};
            wait_cnt_r <= {WAIT_W{1'b0}};
            beat_cnt_r <= {BEAT_W{1'b0}};
            line_buf_r <= {LINE_BITS{1'b0}};
            rdata_r    <= {LINE_BITS{1'b0}};
            resp_r     <= 1'b0;
            error_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pmem_read | pmem_write) begin
                        // A simultaneous read+write is serviced as a write.
                        op_write_r <= pmem_write;
                        index_r    <= pmem_address[INDEX_BITS+3:4];
                        line_buf_r <= pmem_wdata;
                        wait_cnt_r <= WAIT_LOAD;
                        if (pmem_read & pmem_write) begin
                            error_r <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == {WAIT_W{1'b0}}) begin
                        beat_cnt_r <= {BEAT_W{1'b0}};
                    end else begin
                        wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
                    end
                end
                XFER: begin
                    // Read data for beat b-1 arrives while beat b is addressed.
                    if (!op_write_r && (beat_cnt_r != {BEAT_W{1'b0}})) begin
                        line_buf_r[(int'(beat_cnt_r) - 1) * BEAT_WIDTH +: BEAT_WIDTH] <= sram_rdata_s;
                    end
                    if (beat_cnt_r != LAST_BEAT) begin
                        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                    end
                end
                RESP: begin
                    if (!op_write_r) begin
                        rdata_r <= rdata_full_s;
                    end
                end
                default: begin
                    op_write_r <= op_write_r;
                end
            endcase
            resp_r <= (state_next_s == RESP);
            busy_r <= (state_next_s != IDLE);
        end
    end

    assign pmem_resp  = resp_r;
    assign pmem_error = error_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder: a line model plus a queue of
// expected read lines, compared when each read response arrives.
module tb_pmem_line_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp, pmem_error, busy;

    logic         b_read, b_write;
    logic [15:0]  b_address;
    logic [127:0] b_wdata, b_rdata;
    logic         b_resp, b_error, b_busy;

    int checks   = 0;
    int failures = 0;
    int cycle_cnt = 0;

    logic [127:0] model [int];
    logic [127:0] exp_q [$];
    logic [127:0] last_read;
    bit           cur_is_read;
    int           resp_at;

    always #5 clk = ~clk;

    // Free-running cycle counter for measuring spacing between responses.
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    pmem_line_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .pmem_error   (pmem_error),
        .busy         (busy)
    );

    pmem_line_responder #(
        .LATENCY    (1),
        .BEAT_WIDTH (32),
        .INDEX_BITS (12)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (b_read),
        .pmem_write   (b_write),
        .pmem_address (b_address),
        .pmem_wdata   (b_wdata),
        .pmem_rdata   (b_rdata),
        .pmem_resp    (b_resp),
        .pmem_error   (b_error),
        .busy         (b_busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request (cycle 0 starts just after a rising edge unless at_once).
    task automatic start_op(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [127:0] wd, input bit at_once);
        if (!at_once) begin
            @(posedge clk);
            #1;
        end
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        cur_is_read  = rd & ~wr;
        if (wr) model[int'(addr[15:4])] = wd;
        else if (rd) exp_q.push_back(model[int'(addr[15:4])]);
    endtask

    // Wait (bounded) for the response; check its cycle, busy coverage and data.
    task automatic wait_resp(input int exp_cyc, input string tag);
        int  busy_cnt = 0;
        int  cyc = -1;
        logic [127:0] exp;
        for (int c = 0; c < 64 && cyc < 0; c++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (pmem_resp === 1'b1) cyc = c;
        end
        check({tag, "_seen"}, 128'(cyc >= 0), 128'd1);
        if (cyc >= 0) begin
            resp_at = cycle_cnt;
            check({tag, "_cycle"}, 128'(cyc), 128'(exp_cyc));
            check({tag, "_busy"}, 128'(busy_cnt), 128'(exp_cyc));
            if (cur_is_read) begin
                exp = exp_q.pop_front();
                check({tag, "_rdata"}, pmem_rdata, exp);
                last_read = exp;
            end else begin
                check({tag, "_rdata_hold"}, pmem_rdata, last_read);
            end
        end else begin
            exp_q.delete();
        end
    endtask

    // Drop the request and confirm the pulse lasted one cycle and rdata holds.
    task automatic finish_op(input string tag);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, 128'(pmem_resp), 128'd0);
        check({tag, "_held"}, pmem_rdata, last_read);
    endtask

    // One operation on the LATENCY=1 / 32-bit-beat instance: resp in cycle 6.
    task automatic b_op(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [127:0] wd, input logic [127:0] exp_data, input string tag);
        int cyc = -1;
        @(posedge clk);
        #1;
        b_read = rd; b_write = wr; b_address = addr; b_wdata = wd;
        for (int c = 0; c < 64 && cyc < 0; c++) begin
            @(negedge clk);
            if (b_resp === 1'b1) cyc = c;
        end
        b_read = 1'b0; b_write = 1'b0;
        check({tag, "_cycle"}, 128'(cyc), 128'd6);
        if (rd) check({tag, "_rdata"}, b_rdata, exp_data);
        @(negedge clk);
        check({tag, "_pulse"}, 128'(b_resp), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d1, d3, d4, d6a, d6b, db, d5a, d5b;
        int t_first, resp_cnt;
        d1  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        d3  = 128'hA5A5_0F0F_1234_5678_DEAD_BEEF_CAFE_F00D;
        d4  = {128{1'b1}};
        d6a = 128'h0202_0202_1111_2222_3333_4444_5555_6666;
        d6b = 128'h1010_2020_3030_4040_5050_6060_7070_8080;
        db  = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
        d5a = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
        d5b = 128'h0BAD_CAFE_0BAD_CAFE_1357_9BDF_2468_ACE0;
        last_read = 128'd0;
        cur_is_read = 1'b0;
        rst_n = 1'b0;
        pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = 16'h0000; pmem_wdata = 128'd0;
        b_read = 1'b0; b_write = 1'b0; b_address = 16'h0000; b_wdata = 128'd0;
        repeat (3) @(negedge clk);
        check("reset_resp", 128'(pmem_resp), 128'd0);
        check("reset_rdata", pmem_rdata, 128'd0);
        check("reset_error", 128'(pmem_error), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;

        // Write then read back one line; second read repeats the default timing.
        start_op(1'b0, 1'b1, 16'h1234, d1, 1'b0); wait_resp(7, "t1_wr"); finish_op("t1_wr");
        start_op(1'b1, 1'b0, 16'h1234, 128'd0, 1'b0); wait_resp(7, "t1_rd"); finish_op("t1_rd");
        start_op(1'b1, 1'b0, 16'h1234, 128'd0, 1'b0); wait_resp(7, "t2_rd"); finish_op("t2_rd");

        // Offset bits within a line are ignored.
        start_op(1'b0, 1'b1, 16'h0040, d3, 1'b0); wait_resp(7, "t3_wr"); finish_op("t3_wr");
        start_op(1'b1, 1'b0, 16'h004E, 128'd0, 1'b0); wait_resp(7, "t3_rd"); finish_op("t3_rd");

        // Read and write together: write wins, error sticks.
        start_op(1'b1, 1'b1, 16'h0100, d4, 1'b0); wait_resp(7, "t4_both");
        check("t4_error_set", 128'(pmem_error), 128'd1);
        finish_op("t4_both");
        start_op(1'b1, 1'b0, 16'h0100, 128'd0, 1'b0); wait_resp(7, "t4_rd"); finish_op("t4_rd");
        check("t4_error_held", 128'(pmem_error), 128'd1);

        // Back-to-back reads with the request held across resp.
        start_op(1'b0, 1'b1, 16'h0200, d6a, 1'b0); wait_resp(7, "t6_wa"); finish_op("t6_wa");
        start_op(1'b0, 1'b1, 16'h0210, d6b, 1'b0); wait_resp(7, "t6_wb"); finish_op("t6_wb");
        start_op(1'b1, 1'b0, 16'h0200, 128'd0, 1'b0); wait_resp(7, "t6_ra");
        t_first = resp_at;
        start_op(1'b1, 1'b0, 16'h0210, 128'd0, 1'b1); wait_resp(7, "t6_rb");
        // Seven non-resp cycles between the two pulses.
        check("t6_gap", 128'(resp_at - t_first), 128'd8);
        finish_op("t6_rb");

        // Short-latency, four-beat configuration.
        b_op(1'b0, 1'b1, 16'h0550, db, 128'd0, "tb_wr");
        b_op(1'b1, 1'b0, 16'h0550, 128'd0, db, "tb_rd");

        // Reset in the middle of a write's beat transfer.
        start_op(1'b0, 1'b1, 16'h0300, d5a, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        pmem_write = 1'b0;
        #1;
        check("t5_rst_resp", 128'(pmem_resp), 128'd0);
        check("t5_rst_rdata", pmem_rdata, 128'd0);
        check("t5_rst_error", 128'(pmem_error), 128'd0);
        check("t5_rst_busy", 128'(busy), 128'd0);
        last_read = 128'd0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resp_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (pmem_resp === 1'b1) resp_cnt++;
        end
        check("t5_no_resp", 128'(resp_cnt), 128'd0);
        start_op(1'b0, 1'b1, 16'h0300, d5b, 1'b0); wait_resp(7, "t5_wr"); finish_op("t5_wr");
        start_op(1'b1, 1'b0, 16'h0300, 128'd0, 1'b0); wait_resp(7, "t5_rd"); finish_op("t5_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
